regfile_param: RTL and testbench
================================

# regfile_param

Parametrised, clocked register file that succeeds the unclocked 32x32 block in the CPU datapath. It provides two combinational read ports and one synchronous write port with write-to-read bypass. It adds a per-register pending-write scoreboard for pipeline hazard detection and a clear sequencer that zeroes the array on request. It sits between decode (read and scoreboard-set side) and writeback (write side).

## Interface
Parameters:
- DATA_W, 32, data width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- READ_LIMIT, 23, highest readable and writable address; reads above return 0 and writes above are dropped; legal range 0..DEPTH-1

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rd_addr1  in  ADDR_W  read port 1 address
- rd_data1  out  DATA_W  read port 1 data, combinational
- rd_addr2  in  ADDR_W  read port 2 address
- rd_data2  out  DATA_W  read port 2 data, combinational
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- sb_set_en  in  1  mark sb_set_addr as pending (producer issued)
- sb_set_addr  in  ADDR_W  scoreboard set address
- sb_pend1  out  1  pending bit of rd_addr1, combinational
- sb_pend2  out  1  pending bit of rd_addr2, combinational
- clr_req  in  1  start clear sequence (single-cycle pulse or level)
- busy  out  1  clear sequence in progress

## Operation
- Storage: DEPTH x DATA_W array plus a DEPTH-bit pending vector.
- Read (port n): if busy, or rd_addrn > READ_LIMIT, then rd_datan = 0. Else, if wr_en and wr_addr == rd_addrn, rd_datan = wr_data (bypass). Otherwise rd_datan = mem[rd_addrn].
- sb_pendn = pending[rd_addrn] when rd_addrn <= READ_LIMIT and not busy; otherwise 0.
- Write: on clk rise with wr_en, not busy, and wr_addr <= READ_LIMIT, mem[wr_addr] <= wr_data and pending[wr_addr] <= 0.
- Scoreboard set: on clk rise with sb_set_en, not busy, and sb_set_addr <= READ_LIMIT, pending[sb_set_addr] <= 1.
- Same-cycle write and set to the same address: the set wins, so the pending bit ends at 1 and the data is still written.
- Clear FSM states:
  - IDLE: clr_req = 1 moves to CLEAR with cnt <= 0.
  - CLEAR: each cycle, mem[cnt] <= 0, pending[cnt] <= 0, cnt <= cnt + 1. When cnt == DEPTH-1, return to IDLE.
- Clear covers all DEPTH entries, including those above READ_LIMIT.
- clr_req is ignored while in CLEAR; it does not restart the sequence.
- wr_en and sb_set_en are ignored (dropped) while busy. Upstream must stall on busy.
- cnt is ADDR_W bits wide and wraps naturally. The terminal compare is on DEPTH-1.

## Timing
- Reset (rst_n low, asynchronous): all mem = 0, all pending = 0, FSM = IDLE, cnt = 0, busy = 0. All outputs are consequently 0 during reset.
- Read latency: 0 cycles (combinational). A write becomes visible through bypass in the same cycle and through the array from the next cycle.
- Scoreboard: a set at edge N gives sb_pend = 1 from after edge N. A clearing write at edge M gives sb_pend = 0 from after edge M.
- busy is registered (busy = state == CLEAR). It rises the cycle after clr_req is sampled and stays high for exactly DEPTH cycles.
- rst_n asserted mid-clear: FSM aborts to IDLE immediately and the array is zeroed by reset.
- rst_n deassertion is synchronised externally; the first active edge after release is treated as an ordinary cycle.

## Test plan
- Reset then read: rd_addr1 = 0..31 -> rd_data1 = 0, sb_pend1 = 0, busy = 0.
- Write then read: write 5 to addr 16 and 2 to addr 17. Reading 16/17 on the next cycle -> 5/2. A same-cycle read of 16 during the write -> 5 via bypass.
- Read limit: write 0xDEAD to addr 24 -> the write is dropped. rd_addr = 24 -> 0. Write 7 to addr 23 -> reads 7.
- Scoreboard: sb_set addr 3 -> sb_pend = 1 next cycle. Write addr 3 -> sb_pend = 0. Simultaneous set and write on addr 3 -> sb_pend = 1 and data updated.
- Clear: fill regs 0..23 with 1..24, then pulse clr_req -> busy is high for 32 cycles. Reads return 0 while busy. Writes issued during busy are dropped. After busy falls, all reads are 0 and all pending bits are 0.
- Reset mid-clear: assert rst_n low at clear cycle 10 -> busy = 0 immediately, array zero. After release, a new write and read work normally.

Source files
------------

// File: rtl/regfile_param_if.sv
// Bus between decode/writeback and the register file: read ports, write port,
// scoreboard set/query and the clear handshake.
interface regfile_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rd_addr1;
  logic [DATA_W-1:0] rd_data1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data2;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              sb_set_en;
  logic [ADDR_W-1:0] sb_set_addr;
  logic              sb_pend1;
  logic              sb_pend2;
  logic              clr_req;
  logic              busy;

  modport master (
    output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr, clr_req,
    input  rd_data1, rd_data2, sb_pend1, sb_pend2, busy
  );

  modport slave (
    input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr, clr_req,
    output rd_data1, rd_data2, sb_pend1, sb_pend2, busy
  );
endinterface

// File: rtl/regfile_param.sv
// Clocked 2R/1W register file with write-to-read bypass, a pending-write
// scoreboard for hazard detection and a sequential clear of the whole array.
module regfile_param #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int READ_LIMIT = 23
) (
  input  logic           clk,
  input  logic           rst_n,
  regfile_param_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(READ_LIMIT);
  localparam logic [ADDR_W-1:0] LAST  = '1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic              busy;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic              wr_ok, set_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
    end
  end

  // clr_req is only looked at in IDLE, so a request mid-clear never restarts it
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.clr_req) state_nxt = CLEAR;
      CLEAR:   if (cnt == LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CLEAR);
  end

  assign bus.busy = busy;
  assign wr_ok    = bus.wr_en && !busy && (bus.wr_addr <= LIMIT);
  assign set_ok   = bus.sb_set_en && !busy && (bus.sb_set_addr <= LIMIT);

  // The set is applied after the write's clear so a same-address set wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      pending <= '0;
    end else if (busy) begin
      mem[cnt]     <= '0;
      pending[cnt] <= 1'b0;
    end else begin
      if (wr_ok) begin
        mem[bus.wr_addr]     <= bus.wr_data;
        pending[bus.wr_addr] <= 1'b0;
      end
      if (set_ok) pending[bus.sb_set_addr] <= 1'b1;
    end
  end

  always_comb begin
    bus.rd_data1 = '0;
    bus.sb_pend1 = 1'b0;
    if (!busy && bus.rd_addr1 <= LIMIT) begin
      bus.sb_pend1 = pending[bus.rd_addr1];
      if (bus.wr_en && bus.wr_addr == bus.rd_addr1)
        bus.rd_data1 = bus.wr_data;
      else
        bus.rd_data1 = mem[bus.rd_addr1];
    end
  end

  always_comb begin
    bus.rd_data2 = '0;
    bus.sb_pend2 = 1'b0;
    if (!busy && bus.rd_addr2 <= LIMIT) begin
      bus.sb_pend2 = pending[bus.rd_addr2];
      if (bus.wr_en && bus.wr_addr == bus.rd_addr2)
        bus.rd_data2 = bus.wr_data;
      else
        bus.rd_data2 = mem[bus.rd_addr2];
    end
  end
endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: reset, bypass, read limit, scoreboard,
// clear sequence and reset during clear.
module tb_regfile_param;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   busy_cycles;

  regfile_param_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile_param #(.DATA_W(32), .ADDR_W(5), .READ_LIMIT(23)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.wr_en       = 1'b0;
    bus.wr_addr     = '0;
    bus.wr_data     = '0;
    bus.sb_set_en   = 1'b0;
    bus.sb_set_addr = '0;
    bus.clr_req     = 1'b0;
  endtask

  // Drive inputs just after the falling edge, check combinational outputs 1ns later
  task automatic step();
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    bus.rd_addr1 = '0;
    bus.rd_addr2 = '0;
    idle_inputs();

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_rd1", bus.rd_data1, 32'd0);
    rst_n = 1'b1;
    step();
    for (int a = 0; a < 32; a++) begin
      bus.rd_addr1 = 5'(a);
      #1;
      check("init_rd", bus.rd_data1, 32'd0);
      check("init_pend", 32'(bus.sb_pend1), 32'd0);
    end
    check("init_busy", 32'(bus.busy), 32'd0);

    // Write then read, with same-cycle bypass
    bus.wr_en = 1'b1; bus.wr_addr = 5'd16; bus.wr_data = 32'd5;
    bus.rd_addr1 = 5'd16;
    #1;
    check("bypass16", bus.rd_data1, 32'd5);
    step();
    bus.wr_en = 1'b1; bus.wr_addr = 5'd17; bus.wr_data = 32'd2;
    step();
    bus.rd_addr1 = 5'd16; bus.rd_addr2 = 5'd17;
    #1;
    check("rd16", bus.rd_data1, 32'd5);
    check("rd17", bus.rd_data2, 32'd2);

    // Read limit
    bus.wr_en = 1'b1; bus.wr_addr = 5'd24; bus.wr_data = 32'hDEAD;
    bus.rd_addr1 = 5'd24;
    #1;
    check("bypass24", bus.rd_data1, 32'd0);
    step();
    bus.rd_addr1 = 5'd24;
    #1;
    check("rd24", bus.rd_data1, 32'd0);
    bus.wr_en = 1'b1; bus.wr_addr = 5'd23; bus.wr_data = 32'd7;
    step();
    bus.rd_addr2 = 5'd23;
    #1;
    check("rd23", bus.rd_data2, 32'd7);

    // Scoreboard set, clearing write, then simultaneous set+write
    bus.rd_addr1 = 5'd3;
    bus.sb_set_en = 1'b1; bus.sb_set_addr = 5'd3;
    #1;
    check("pend3_before", 32'(bus.sb_pend1), 32'd0);
    step();
    #1;
    check("pend3_set", 32'(bus.sb_pend1), 32'd1);
    bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'd9;
    step();
    #1;
    check("pend3_clr", 32'(bus.sb_pend1), 32'd0);
    check("rd3_9", bus.rd_data1, 32'd9);
    bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'h33;
    bus.sb_set_en = 1'b1; bus.sb_set_addr = 5'd3;
    step();
    #1;
    check("pend3_both", 32'(bus.sb_pend1), 32'd1);
    check("rd3_33", bus.rd_data1, 32'h33);

    // Fill 0..23 with 1..24 and mark a few pending
    for (int a = 0; a < 24; a++) begin
      bus.wr_en = 1'b1; bus.wr_addr = 5'(a); bus.wr_data = 32'(a + 1);
      step();
    end
    bus.sb_set_en = 1'b1; bus.sb_set_addr = 5'd5;
    step();
    bus.sb_set_en = 1'b1; bus.sb_set_addr = 5'd22;
    step();
    bus.rd_addr1 = 5'd0; bus.rd_addr2 = 5'd23;
    #1;
    check("fill0", bus.rd_data1, 32'd1);
    check("fill23", bus.rd_data2, 32'd24);
    bus.rd_addr1 = 5'd5; bus.rd_addr2 = 5'd22;
    #1;
    check("pend5", 32'(bus.sb_pend1), 32'd1);
    check("pend22", 32'(bus.sb_pend2), 32'd1);

    // Clear sequence: busy for exactly 32 cycles, traffic dropped, re-request ignored
    bus.clr_req = 1'b1;
    #1;
    check("busy_pre", 32'(bus.busy), 32'd0);
    step();
    busy_cycles = 0;
    for (int g = 0; g < 100 && bus.busy; g++) begin
      busy_cycles++;
      bus.clr_req     = (busy_cycles == 5);
      bus.wr_en       = 1'b1; bus.wr_addr = 5'd2; bus.wr_data = 32'hBEEF;
      bus.sb_set_en   = 1'b1; bus.sb_set_addr = 5'd4;
      bus.rd_addr1    = 5'd2; bus.rd_addr2 = 5'd5;
      #1;
      if (busy_cycles <= 3 || busy_cycles == 31) begin
        check("busy_rd", bus.rd_data1, 32'd0);
        check("busy_pend", 32'(bus.sb_pend2), 32'd0);
      end
      step();
    end
    check("busy_len", 32'(busy_cycles), 32'd32);
    #1;
    for (int a = 0; a < 32; a++) begin
      bus.rd_addr1 = 5'(a); bus.rd_addr2 = 5'(a);
      #1;
      check("clr_rd", bus.rd_data1, 32'd0);
      check("clr_pend", 32'(bus.sb_pend2), 32'd0);
    end
    step();
    #1;
    check("busy_after", 32'(bus.busy), 32'd0);

    // Reset mid-clear
    bus.wr_en = 1'b1; bus.wr_addr = 5'd20; bus.wr_data = 32'h77;
    step();
    bus.sb_set_en = 1'b1; bus.sb_set_addr = 5'd21;
    step();
    bus.rd_addr1 = 5'd20; bus.rd_addr2 = 5'd21;
    #1;
    check("pre_rd20", bus.rd_data1, 32'h77);
    check("pre_pend21", 32'(bus.sb_pend2), 32'd1);
    bus.clr_req = 1'b1;
    step();
    repeat (9) step();
    #1;
    check("mid_busy", 32'(bus.busy), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rd20", bus.rd_data1, 32'd0);
    check("rst_pend21", 32'(bus.sb_pend2), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    #1;
    check("post_busy", 32'(bus.busy), 32'd0);
    bus.wr_en = 1'b1; bus.wr_addr = 5'd12; bus.wr_data = 32'hABC;
    step();
    bus.rd_addr1 = 5'd12; bus.rd_addr2 = 5'd20;
    #1;
    check("post_rd12", bus.rd_data1, 32'hABC);
    check("post_rd20", bus.rd_data2, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
